// File: rtl/bnw_game_pkg.sv
// rtl/bnw_game_pkg.sv - shared game constants, judge state/grade encodings and saturating helper
package bnw_game_pkg;

    localparam logic [9:0]  H_SPAWN       = 10'd120;
    localparam logic [9:0]  H_BOTTOM      = 10'd720;
    localparam logic [15:0] SCORE_PERFECT = 16'd3;
    localparam logic [15:0] SCORE_GOOD    = 16'd1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LIVE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        JUDGE_NONE,
        JUDGE_PERFECT,
        JUDGE_GOOD,
        JUDGE_MISS
    } judge_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/lane_hit_judge_if.sv
// rtl/lane_hit_judge_if.sv - lane judge bundle: spawner/key inputs and grading outputs
interface lane_hit_judge_if;
    logic        restart;
    logic        stop_or_endgame;
    logic [9:0]  block_h;
    logic        key;
    logic        hit_perfect;
    logic        hit_good;
    logic        miss;
    logic        block_hide;
    logic [7:0]  combo;
    logic [15:0] score;

    modport master (
        output restart, stop_or_endgame, block_h, key,
        input  hit_perfect, hit_good, miss, block_hide, combo, score
    );

    modport slave (
        input  restart, stop_or_endgame, block_h, key,
        output hit_perfect, hit_good, miss, block_hide, combo, score
    );
endinterface

// File: rtl/key_rise_detect.sv
// rtl/key_rise_detect.sv - 2-flop key synchroniser plus rising-edge pulse, shared by all lanes
module key_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic key,
    output logic key_rise
);
    logic sync1, sync2, sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign key_rise = sync2 & ~sync3;
endmodule

// File: rtl/lane_hit_judge.sv
// rtl/lane_hit_judge.sv - grades each falling lane block once as PERFECT, GOOD or MISS
module lane_hit_judge #(
    parameter int HIT_LINE    = 600,
    parameter int PERFECT_WIN = 8,
    parameter int GOOD_WIN    = 24,
    parameter int H_BOTTOM    = 720,
    parameter bit PEN_STRAY   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    lane_hit_judge_if.slave   bus
);
    import bnw_game_pkg::*;

    localparam logic signed [10:0] HIT_S  = 11'(HIT_LINE);
    localparam logic signed [10:0] PERF_S = 11'(PERFECT_WIN);
    localparam logic signed [10:0] GOOD_S = 11'(GOOD_WIN);
    localparam logic signed [10:0] NEG_GOOD_S = -GOOD_S;
    localparam logic [9:0]         H_B    = 10'(H_BOTTOM);

    logic        key_rise;
    logic [1:0]  state, state_nxt;
    logic [9:0]  prev_h;
    logic        hit_perfect_q, hit_good_q, miss_q;
    logic [7:0]  combo_q;
    logic [15:0] score_q;
    judge_t      jud;

    logic signed [10:0] d, abs_d;
    logic spawn, window, past, perfect, stray, at_bottom;

    // Keeps running while frozen so a key held across a pause cannot fire on resume.
    key_rise_detect u_key (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.restart),
        .key      (bus.key),
        .key_rise (key_rise)
    );

    assign d         = $signed({1'b0, bus.block_h}) - HIT_S;
    assign abs_d     = d[10] ? -d : d;
    assign at_bottom = (bus.block_h == H_B);
    assign spawn     = (bus.block_h < prev_h);
    assign perfect   = (abs_d <= PERF_S);
    assign window    = (abs_d <= GOOD_S);
    assign past      = (d > GOOD_S) || at_bottom;
    assign stray     = key_rise && (d < NEG_GOOD_S) && PEN_STRAY;

    always_comb begin
        state_nxt = state;
        jud       = JUDGE_NONE;
        case (state)
            ST_IDLE: begin
                if (spawn) state_nxt = ST_LIVE;
            end
            ST_LIVE: begin
                // A respawn means the old block left unjudged; the new one starts fresh.
                if (spawn) begin
                    jud = JUDGE_MISS;
                end else if (key_rise && perfect) begin
                    jud       = JUDGE_PERFECT;
                    state_nxt = ST_DONE;
                end else if (key_rise && window) begin
                    jud       = JUDGE_GOOD;
                    state_nxt = ST_DONE;
                end else if (past || stray) begin
                    jud       = JUDGE_MISS;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (spawn)          state_nxt = ST_LIVE;
                else if (at_bottom) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            prev_h        <= H_B;
            hit_perfect_q <= 1'b0;
            hit_good_q    <= 1'b0;
            miss_q        <= 1'b0;
            combo_q       <= 8'd0;
            score_q       <= 16'd0;
        end else if (bus.restart) begin
            state         <= ST_IDLE;
            prev_h        <= H_B;
            hit_perfect_q <= 1'b0;
            hit_good_q    <= 1'b0;
            miss_q        <= 1'b0;
            combo_q       <= 8'd0;
            score_q       <= 16'd0;
        end else if (bus.stop_or_endgame) begin
            hit_perfect_q <= 1'b0;
            hit_good_q    <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            state         <= state_nxt;
            prev_h        <= bus.block_h;
            hit_perfect_q <= (jud == JUDGE_PERFECT);
            hit_good_q    <= (jud == JUDGE_GOOD);
            miss_q        <= (jud == JUDGE_MISS);
            case (jud)
                JUDGE_PERFECT: begin
                    combo_q <= (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
                    score_q <= sat_add16(score_q, SCORE_PERFECT);
                end
                JUDGE_GOOD: begin
                    combo_q <= (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
                    score_q <= sat_add16(score_q, SCORE_GOOD);
                end
                JUDGE_MISS: combo_q <= 8'd0;
                default: ;
            endcase
        end
    end

    assign bus.hit_perfect = hit_perfect_q;
    assign bus.hit_good    = hit_good_q;
    assign bus.miss        = miss_q;
    assign bus.block_hide  = (state == ST_DONE);
    assign bus.combo       = combo_q;
    assign bus.score       = score_q;
endmodule

// File: tb/tb_lane_hit_judge.sv
// tb/tb_lane_hit_judge.sv - scoreboard bench for lane_hit_judge (stray penalty on and off)
module tb_lane_hit_judge;

    typedef struct packed {
        logic        k1, k2, k3;
        logic [9:0]  prev;
        logic [1:0]  st;
        logic [7:0]  combo;
        logic [15:0] score;
        logic        hp, hg, ms;
    } model_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   np0, ng0, nm0, np1, ng1, nm1;
    model_t m0, m1;
    logic [27:0] q0[$];
    logic [27:0] q1[$];

    lane_hit_judge_if bus0();
    lane_hit_judge_if bus1();

    lane_hit_judge #(.PEN_STRAY(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    lane_hit_judge #(.PEN_STRAY(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

    function automatic model_t mreset();
        model_t r;
        r = '0;
        r.prev = 10'd720;
        return r;
    endfunction

    function automatic model_t mstep(model_t m, logic rst, logic stop, logic [9:0] h,
                                     logic key, bit pen);
        model_t n;
        logic   rise, spawn, past;
        int     d;
        n    = m;
        rise = m.k2 && !m.k3;
        if (rst) return mreset();
        n.k1 = key; n.k2 = m.k1; n.k3 = m.k2;
        n.hp = 1'b0; n.hg = 1'b0; n.ms = 1'b0;
        if (stop) return n;
        d     = int'(h) - 600;
        spawn = (h < m.prev);
        past  = (d > 24) || (h == 10'd720);
        n.prev = h;
        if (m.st == 2'd0) begin
            if (spawn) n.st = 2'd1;
        end else if (m.st == 2'd1) begin
            if (spawn) n.ms = 1'b1;
            else if (rise && d >= -8 && d <= 8) begin n.hp = 1'b1; n.st = 2'd2; end
            else if (rise && d >= -24 && d <= 24) begin n.hg = 1'b1; n.st = 2'd2; end
            else if (past) begin n.ms = 1'b1; n.st = 2'd2; end
            else if (rise && d < -24 && pen) begin n.ms = 1'b1; n.st = 2'd2; end
        end else begin
            if (spawn) n.st = 2'd1;
            else if (h == 10'd720) n.st = 2'd0;
        end
        if (n.hp || n.hg) begin
            n.combo = (m.combo == 8'd255) ? 8'd255 : m.combo + 8'd1;
            n.score = (int'(m.score) + (n.hp ? 3 : 1) > 65535) ? 16'hFFFF
                      : m.score + (n.hp ? 16'd3 : 16'd1);
        end else if (n.ms) begin
            n.combo = 8'd0;
        end
        return n;
    endfunction

    function automatic logic [27:0] exp_of(model_t m);
        return {m.hp, m.hg, m.ms, (m.st == 2'd2), m.combo, m.score};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    endtask

    task automatic cyc();
        logic [27:0] e, o;
        m0 = mstep(m0, bus0.restart, bus0.stop_or_endgame, bus0.block_h, bus0.key, 1'b1);
        q0.push_back(exp_of(m0));
        m1 = mstep(m1, bus1.restart, bus1.stop_or_endgame, bus1.block_h, bus1.key, 1'b0);
        q1.push_back(exp_of(m1));
        @(posedge clk);
        #1;
        o = {bus0.hit_perfect, bus0.hit_good, bus0.miss, bus0.block_hide, bus0.combo, bus0.score};
        e = q0.pop_front();
        chk("dut0_outputs", {4'h0, o}, {4'h0, e});
        o = {bus1.hit_perfect, bus1.hit_good, bus1.miss, bus1.block_hide, bus1.combo, bus1.score};
        e = q1.pop_front();
        chk("dut1_outputs", {4'h0, o}, {4'h0, e});
        np0 += int'(bus0.hit_perfect); ng0 += int'(bus0.hit_good); nm0 += int'(bus0.miss);
        np1 += int'(bus1.hit_perfect); ng1 += int'(bus1.hit_good); nm1 += int'(bus1.miss);
    endtask

    task automatic clr_counts();
        np0 = 0; ng0 = 0; nm0 = 0; np1 = 0; ng1 = 0; nm1 = 0;
    endtask

    task automatic idle(input int n);
        bus0.block_h = 10'd720; bus0.key = 1'b0; bus0.stop_or_endgame = 1'b0; bus0.restart = 1'b0;
        bus1.block_h = 10'd720; bus1.key = 1'b0; bus1.stop_or_endgame = 1'b0; bus1.restart = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_restart();
        bus0.restart = 1'b1; bus1.restart = 1'b1;
        cyc();
        bus0.restart = 1'b0; bus1.restart = 1'b0;
    endtask

    // Key is high for p1 <= h < r1 and for h >= p2; stop is high only at h == stop_h.
    task automatic ramp(input int sel, input int lo, input int hi, input int stp,
                        input int p1, input int r1, input int p2, input int stop_h);
        for (int h = lo; h <= hi; h += stp) begin
            if (sel == 0) begin
                bus0.block_h = 10'(h);
                bus0.key = ((h >= p1) && (h < r1)) || (h >= p2);
                bus0.stop_or_endgame = (h == stop_h);
            end else begin
                bus1.block_h = 10'(h);
                bus1.key = ((h >= p1) && (h < r1)) || (h >= p2);
                bus1.stop_or_endgame = (h == stop_h);
            end
            cyc();
        end
    endtask

    task automatic quick_hit();
        bus0.key = 1'b1;
        bus0.block_h = 10'd580; cyc();
        bus0.block_h = 10'd590; cyc();
        bus0.block_h = 10'd600; cyc();
        idle(3);
    endtask

    initial begin
        total = 0; passed = 0;
        clr_counts();
        rst_n = 1'b0;
        bus0.block_h = 10'd720; bus0.key = 1'b0; bus0.stop_or_endgame = 1'b0; bus0.restart = 1'b0;
        bus1.block_h = 10'd720; bus1.key = 1'b0; bus1.stop_or_endgame = 1'b0; bus1.restart = 1'b0;
        m0 = mreset(); m1 = mreset();
        #12;
        chk("reset_outputs", {4'h0, bus0.hit_perfect, bus0.hit_good, bus0.miss, bus0.block_hide,
                              bus0.combo, bus0.score}, 32'h0);
        rst_n = 1'b1;
        idle(3);

        // Perfect hit: rise sampled at 596.
        clr_counts();
        ramp(0, 120, 596, 4, 588, 2000, 2000, -1);
        chk("perfect_hide", {31'h0, bus0.block_hide}, 32'd1);
        ramp(0, 600, 720, 4, 0, 2000, 2000, -1);
        chk("perfect_count", np0, 1);
        chk("perfect_score", {16'h0, bus0.score}, 32'd3);
        chk("perfect_combo", {24'h0, bus0.combo}, 32'd1);
        chk("perfect_idle_hide", {31'h0, bus0.block_hide}, 32'd0);
        idle(3);

        // Two GOOD edges (+24, -24), then a rise at +25 graded as past.
        do_restart();
        clr_counts();
        ramp(0, 120, 720, 4, 616, 2000, 2000, -1);
        idle(3);
        ramp(0, 120, 720, 4, 568, 2000, 2000, -1);
        idle(3);
        chk("good_count", ng0, 2);
        chk("good_score", {16'h0, bus0.score}, 32'd2);
        chk("good_combo", {24'h0, bus0.combo}, 32'd2);
        ramp(0, 560, 720, 1, 623, 2000, 2000, -1);
        idle(3);
        chk("past_no_hit", np0 + ng0, 2);
        chk("past_miss", nm0, 1);

        // Combo 5 then an unpressed block: one miss only.
        do_restart();
        for (int b = 0; b < 5; b++) begin
            ramp(0, 120, 720, 8, 584, 2000, 2000, -1);
            idle(3);
        end
        chk("combo5", {24'h0, bus0.combo}, 32'd5);
        clr_counts();
        ramp(0, 120, 720, 8, 2000, 2000, 2000, -1);
        idle(3);
        chk("nokey_miss_count", nm0, 1);
        chk("nokey_combo", {24'h0, bus0.combo}, 32'd0);
        chk("nokey_score", {16'h0, bus0.score}, 32'd15);

        // Stray press at 400: penalised on dut0, ignored on dut1.
        do_restart();
        clr_counts();
        ramp(0, 120, 720, 4, 392, 2000, 2000, -1);
        idle(3);
        ramp(1, 120, 720, 4, 392, 420, 592, -1);
        idle(3);
        chk("stray_miss_pen1", nm0, 1);
        chk("stray_miss_pen0", nm1, 0);
        chk("stray_perfect_pen0", np1, 1);

        // Respawn at 300 while LIVE with a rise landing on the respawn sample.
        clr_counts();
        ramp(0, 120, 500, 4, 496, 2000, 2000, -1);
        ramp(0, 300, 304, 4, 0, 2000, 2000, -1);
        chk("respawn_live", {31'h0, bus0.block_hide}, 32'd0);
        ramp(0, 308, 720, 4, 0, 2000, 2000, -1);
        idle(3);
        chk("respawn_miss", nm0, 2);
        chk("respawn_no_hit", np0 + ng0, 0);

        // Freeze on the sample where the rise would land.
        clr_counts();
        ramp(0, 120, 720, 2, 586, 2000, 2000, 590);
        idle(3);
        chk("freeze_no_hit", np0 + ng0, 0);
        chk("freeze_miss", nm0, 1);

        // Combo saturation.
        do_restart();
        for (int b = 0; b < 257; b++) quick_hit();
        chk("combo_sat", {24'h0, bus0.combo}, 32'd255);
        chk("combo_sat_score", {16'h0, bus0.score}, 32'd771);

        // Async reset in the middle of a live block.
        ramp(0, 120, 400, 4, 2000, 2000, 2000, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {4'h0, bus0.hit_perfect, bus0.hit_good, bus0.miss, bus0.block_hide,
                            bus0.combo, bus0.score}, 32'h0);
        m0 = mreset(); m1 = mreset();
        bus0.block_h = 10'd720;
        #1;
        rst_n = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
